// File: rtl/jtbubl_gfx_romfetch.sv
// jtbubl_gfx_romfetch: graphics ROM port to SDRAM read port bridge with a
// 2-entry, 32-bit word cache (LRU replacement). Misses issue one SDRAM read.
// Optional build macro JTBUBL_GFX_PREFETCH_EN: after each demand fill the next
// word address is prefetched into the other cache entry.
module jtbubl_gfx_romfetch #(
  parameter int              AW     = 18,
  parameter int              SDW    = 22,
  parameter logic [SDW-1:0]  OFFSET = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rom_cs,
  input  logic [AW-1:0]  rom_addr,
  output logic [31:0]    rom_data,
  output logic           rom_ok,
  output logic           sdram_req,
  output logic [SDW-1:0] sdram_addr,
  input  logic           sdram_ack,
  input  logic           sdram_rdy,
  input  logic [31:0]    sdram_data
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT
`ifdef JTBUBL_GFX_PREFETCH_EN
    , PREF_REQ, PREF_WAIT
`endif
  } state_t;

  // Video word address to SDRAM word address; the carry out of SDW bits is dropped
  function automatic logic [SDW-1:0] map_addr(input logic [AW-1:0] a);
    return OFFSET + SDW'(a);
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      valid_q;
  logic [AW-1:0]   tag_q  [2];
  logic [31:0]     data_q [2];
  logic            lru_q;
  logic [AW-1:0]   miss_addr_q;
  logic [SDW-1:0]  sdram_addr_q;
  logic            ok_q;
  logic [AW-1:0]   ok_addr_q;
  logic [31:0]     rom_data_q;

  logic            hit0, hit1, hit;
  logic [31:0]     hit_data;
  logic            issue, fill, demand_fill, fill_idx, fill_ok;
`ifdef JTBUBL_GFX_PREFETCH_EN
  logic            pref_idx_q;
  logic [AW-1:0]   pref_addr;
  logic            pref_cached;
  logic            pref_start;

  assign pref_addr   = miss_addr_q + 1'b1;
  assign pref_cached = valid_q[~lru_q] && (tag_q[~lru_q] == pref_addr);
`endif

  assign hit0     = rom_cs && valid_q[0] && (tag_q[0] == rom_addr);
  assign hit1     = rom_cs && valid_q[1] && (tag_q[1] == rom_addr);
  assign hit      = hit0 || hit1;
  assign hit_data = hit0 ? data_q[0] : data_q[1];
  assign fill_ok  = fill && rom_cs && (rom_addr == miss_addr_q);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and per-cycle control strobes
  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    fill        = 1'b0;
    demand_fill = 1'b0;
    fill_idx    = lru_q;
`ifdef JTBUBL_GFX_PREFETCH_EN
    pref_start  = 1'b0;
`endif
    case (state_q)
      IDLE: if (rom_cs && !hit) begin
        state_d = REQ;
        issue   = 1'b1;
      end
      REQ: if (sdram_ack) begin
        // ack and rdy together: the fill completes in the same cycle
        if (sdram_rdy) begin
          fill        = 1'b1;
          demand_fill = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (sdram_rdy) begin
        fill        = 1'b1;
        demand_fill = 1'b1;
        state_d     = IDLE;
      end
`ifdef JTBUBL_GFX_PREFETCH_EN
      PREF_REQ: begin
        fill_idx = pref_idx_q;
        if (sdram_ack) begin
          if (sdram_rdy) begin
            fill    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = PREF_WAIT;
          end
        end
      end
      PREF_WAIT: begin
        fill_idx = pref_idx_q;
        if (sdram_rdy) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef JTBUBL_GFX_PREFETCH_EN
    if (demand_fill && !pref_cached) begin
      state_d    = PREF_REQ;
      pref_start = 1'b1;
    end
`endif
  end

  // Control state: valid bits, LRU, request address, reported word and ok flag
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      lru_q        <= 1'b0;
      miss_addr_q  <= '0;
      sdram_addr_q <= '0;
      ok_q         <= 1'b0;
      ok_addr_q    <= '0;
      rom_data_q   <= '0;
`ifdef JTBUBL_GFX_PREFETCH_EN
      pref_idx_q   <= 1'b0;
`endif
    end else begin
      if (issue) begin
        miss_addr_q  <= rom_addr;
        sdram_addr_q <= map_addr(rom_addr);
      end
`ifdef JTBUBL_GFX_PREFETCH_EN
      // prefetch goes to the entry not holding the demand word; LRU untouched
      if (pref_start) begin
        miss_addr_q  <= pref_addr;
        sdram_addr_q <= map_addr(pref_addr);
        pref_idx_q   <= ~lru_q;
      end
`endif
      if (hit) lru_q <= hit0;
      if (fill) valid_q[fill_idx] <= 1'b1;
      if (demand_fill) lru_q <= ~fill_idx;
      if (fill_ok) begin
        rom_data_q <= sdram_data;
        ok_q       <= 1'b1;
        ok_addr_q  <= miss_addr_q;
      end else if (hit) begin
        rom_data_q <= hit_data;
        ok_q       <= 1'b1;
        ok_addr_q  <= rom_addr;
      end else begin
        ok_q <= 1'b0;
      end
    end
  end

  // Cache tag/data storage, written on every completed fill
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fill_idx]  <= miss_addr_q;
      data_q[fill_idx] <= sdram_data;
    end
  end

  // ok is qualified combinationally so it never covers a changed address
  assign rom_ok     = ok_q && rom_cs && (rom_addr == ok_addr_q);
  assign rom_data   = rom_data_q;
  assign sdram_addr = sdram_addr_q;
`ifdef JTBUBL_GFX_PREFETCH_EN
  assign sdram_req  = (state_q == REQ) || (state_q == PREF_REQ);
`else
  assign sdram_req  = (state_q == REQ);
`endif

endmodule

// File: tb/tb_jtbubl_gfx_romfetch.sv
// Directed bench for jtbubl_gfx_romfetch: two instances in lockstep (OFFSET 0
// and OFFSET 22'h3FFFF0) fed by a simple SDRAM responder.
module tb_jtbubl_gfx_romfetch;
  localparam int AW  = 18;
  localparam int SDW = 22;

  logic           clk;
  logic           rst;
  logic           rom_cs;
  logic [AW-1:0]  rom_addr;
  logic [31:0]    rom_data, rom_data2;
  logic           rom_ok, rom_ok2;
  logic           sdram_req, sdram_req2;
  logic [SDW-1:0] sdram_addr, sdram_addr2;
  logic           sdram_ack, sdram_rdy;
  logic [31:0]    sdram_data;
  logic           force_ack, force_rdy, resp_ack, resp_rdy;
  logic [31:0]    resp_data;
  logic [SDW-1:0] last_addr, last_addr2;
  int             n_checks = 0;
  int             n_fail   = 0;
  int             req_cnt  = 0;
  int             req_cnt2 = 0;
  int             lat      = 4;
  int             base;
  logic           seen;

  assign sdram_ack  = force_ack | resp_ack;
  assign sdram_rdy  = force_rdy | resp_rdy;
  assign sdram_data = resp_data;

  jtbubl_gfx_romfetch #(.AW(AW), .SDW(SDW), .OFFSET(22'h0)) dut (
    .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .sdram_req(sdram_req),
    .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy),
    .sdram_data(sdram_data)
  );

  jtbubl_gfx_romfetch #(.AW(AW), .SDW(SDW), .OFFSET(22'h3FFFF0)) dut2 (
    .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data2), .rom_ok(rom_ok2), .sdram_req(sdram_req2),
    .sdram_addr(sdram_addr2), .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy),
    .sdram_data(sdram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [SDW-1:0] a);
    return (a == 22'h10) ? 32'hDEADBEEF : (32'hA5000000 | 32'(a));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ok(input string tag);
    #1;
    for (int i = 0; i < 40 && !rom_ok; i++) begin
      @(negedge clk);
      #1;
    end
    chk(tag, 32'(rom_ok), 32'd1);
  endtask

  // SDRAM responder: ack one cycle after seeing req, rdy lat cycles after ack
  initial begin
    resp_ack  = 1'b0;
    resp_rdy  = 1'b0;
    resp_data = '0;
    forever begin
      @(negedge clk);
      if (!rst && sdram_req) begin
        req_cnt++;
        if (sdram_req2) req_cnt2++;
        last_addr  = sdram_addr;
        last_addr2 = sdram_addr2;
        resp_ack   = 1'b1;
        if (lat == 0) begin
          resp_rdy  = 1'b1;
          resp_data = mem_word(last_addr);
        end
        @(negedge clk);
        resp_ack = 1'b0;
        resp_rdy = 1'b0;
        if (lat > 0) begin
          repeat (lat - 1) @(negedge clk);
          resp_rdy  = 1'b1;
          resp_data = mem_word(last_addr);
          @(negedge clk);
          resp_rdy = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected end");
    $fatal(1);
  end

  initial begin
    // reset with ack/rdy forced high
    rst = 1'b1; rom_cs = 1'b1; rom_addr = 18'h10;
    force_ack = 1'b1; force_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ok",    32'(rom_ok),     32'd0);
    chk("rst_req",   32'(sdram_req),  32'd0);
    chk("rst_data",  rom_data,        32'h0);
    chk("rst_saddr", 32'(sdram_addr), 32'h0);
    rom_cs = 1'b0; force_ack = 1'b0; force_rdy = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("idle_noreq", 32'(sdram_req), 32'd0);

    // first miss, then hit on re-read
    rom_cs = 1'b1; rom_addr = 18'h10;
    wait_ok("t2_ok");
    chk("t2_data",   rom_data,         32'hDEADBEEF);
    chk("t2_reqcnt", 32'(req_cnt),     32'd1);
    chk("t2_saddr",  32'(last_addr),   32'h000010);
    chk("t2_saddr2", 32'(last_addr2),  32'h000000);
    @(negedge clk);
    rom_cs = 1'b0;
    #1 chk("cs_low_ok", 32'(rom_ok), 32'd0);
    @(negedge clk);
    rom_cs = 1'b1;
    @(negedge clk);
    chk("t2_hit_ok",   32'(rom_ok),    32'd1);
    chk("t2_hit_data", rom_data,       32'hDEADBEEF);
    chk("t2_hit_nreq", 32'(req_cnt),   32'd1);

    // address wrap on OFFSET instance
    rom_addr = 18'h20;
    #1 chk("addr_chg_ok", 32'(rom_ok), 32'd0);
    wait_ok("t3_ok");
    chk("t3_data",   rom_data,        32'hA5000020);
    chk("t3_saddr",  32'(last_addr),  32'h000020);
    chk("t3_wrap",   32'(last_addr2), 32'h000010);
    chk("t3_ok2",    32'(rom_ok2),    32'd1);
    chk("t3_data2",  rom_data2,       32'hA5000020);

    // LRU eviction
    @(negedge clk); rom_addr = 18'h100; wait_ok("t4_f100");
    @(negedge clk); rom_addr = 18'h200; wait_ok("t4_f200");
    @(negedge clk); rom_addr = 18'h100;
    @(negedge clk);
    chk("t4_hit100a", 32'(rom_ok),  32'd1);
    chk("t4_cnt_a",   32'(req_cnt), 32'd4);
    rom_addr = 18'h300; wait_ok("t4_f300");
    chk("t4_cnt_b",   32'(req_cnt), 32'd5);
    @(negedge clk); rom_addr = 18'h100;
    @(negedge clk);
    chk("t4_hit100b", 32'(rom_ok),  32'd1);
    chk("t4_data100", rom_data,     32'hA5000100);
    chk("t4_cnt_c",   32'(req_cnt), 32'd5);
    rom_addr = 18'h200;
    @(negedge clk);
    chk("t4_miss200", 32'(rom_ok),  32'd0);
    wait_ok("t4_f200b");
    chk("t4_cnt_d",   32'(req_cnt), 32'd6);
    chk("t4_data200", rom_data,     32'hA5000200);

    // address change while the fill is in flight
    @(negedge clk);
    base = req_cnt;
    rom_addr = 18'h40;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1 seen = resp_ack;
    end
    chk("t5_ack", 32'(seen), 32'd1);
    @(negedge clk);
    rom_addr = 18'h41;
    #1 chk("t5_ok_low", 32'(rom_ok), 32'd0);
    for (int i = 0; i < 40 && !rom_ok; i++) begin
      @(negedge clk);
      #1;
      if (rom_ok) chk("t5_nostale", rom_data, 32'hA5000041);
    end
    chk("t5_ok",     32'(rom_ok),       32'd1);
    chk("t5_cnt",    32'(req_cnt),      32'(base + 2));
    chk("t5_saddr",  32'(last_addr),    32'h000041);
    @(negedge clk); rom_addr = 18'h40;
    @(negedge clk);
    chk("t5_hit40",  32'(rom_ok),       32'd1);
    chk("t5_data40", rom_data,          32'hA5000040);
    chk("t5_cnt2",   32'(req_cnt),      32'(base + 2));

    // ack and rdy in the same cycle
    lat = 0;
    base = req_cnt;
    rom_addr = 18'h500;
    wait_ok("t7_ok");
    chk("t7_data", rom_data,     32'hA5000500);
    chk("t7_cnt",  32'(req_cnt), 32'(base + 1));
    chk("t7_lock", 32'(req_cnt2), 32'(req_cnt));

    // top-of-range address: prefetch wraps to 0 when enabled
    lat = 4;
    @(negedge clk);
    base = req_cnt;
    rom_addr = 18'h3FFFF;
    wait_ok("t6_ok");
    chk("t6_data", rom_data, 32'hA503FFFF);
    repeat (12) @(negedge clk);
`ifdef JTBUBL_GFX_PREFETCH_EN
    chk("t6_cnt",   32'(req_cnt),   32'(base + 2));
    chk("t6_saddr", 32'(last_addr), 32'h000000);
    rom_addr = 18'h0;
    @(negedge clk);
    chk("t6_hit0",  32'(rom_ok),    32'd1);
    chk("t6_data0", rom_data,       32'hA5000000);
`else
    chk("t6_cnt",   32'(req_cnt),   32'(base + 1));
    chk("t6_saddr", 32'(last_addr), 32'h03FFFF);
    rom_addr = 18'h0;
    @(negedge clk);
    chk("t6_miss0", 32'(rom_ok),    32'd0);
    wait_ok("t6_f0");
    chk("t6_data0", rom_data,       32'hA5000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
